pwm_sequencer: RTL and testbench

Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 output pins. Staged configuration is applied only at PWM period boundaries, so a reconfiguration never produces a truncated or glitched pulse. Sits between the SPI register block and the top-level output pins.

---
 rtl/pwm_sequencer.sv | 158 +++++++++++++++
 tb/tb_pwm_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: drives 16 output pins from SPI-written configuration.
// A new configuration is staged on a valid/ready handshake and becomes active
// only at a PWM period boundary (or at once from IDLE), so pulses are never cut.
// Optional build macro: PWM_STAGGER_EN, which phase-shifts each PWM channel by
// i*(2^CNT_W/16) counter steps so rising edges are spread across the period.
module pwm_sequencer #(
   parameter int unsigned CLK_DIV = 13,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [15:0]      cfg_out_en,
   input  logic [15:0]      cfg_pwm_en,
   input  logic [CNT_W-1:0] cfg_duty,
   output logic [15:0]      pwm_out,
   output logic             period_start,
   output logic             busy
);

   localparam int unsigned       PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]     PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
`ifdef PWM_STAGGER_EN
   localparam int unsigned       STAGGER   = (2 ** CNT_W) / 16;
`endif

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pending_q, pending_d;
   logic [15:0]        stg_out_en_q, stg_out_en_d;
   logic [15:0]        stg_pwm_en_q, stg_pwm_en_d;
   logic [CNT_W-1:0]   stg_duty_q, stg_duty_d;
   logic [15:0]        act_out_en_q, act_out_en_d;
   logic [15:0]        act_pwm_en_q, act_pwm_en_d;
   logic [CNT_W-1:0]   act_duty_q, act_duty_d;
   logic               period_start_q, period_start_d;
   logic [15:0]        pwm_out_q, pwm_out_d;

   logic               tick;
   logic               boundary;
   logic               accept;
   logic               apply;
   logic [CNT_W-1:0]   phase;

   assign cfg_ready    = !pending_q;
   assign pwm_out      = pwm_out_q;
   assign period_start = period_start_q;
   assign busy         = (state_q == RUN);

   // Handshake, staging/apply, prescaler, counter and state transitions.
   always_comb begin
      tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
      boundary = tick && (cnt_q == CNT_MAX);
      accept   = cfg_valid && !pending_q;
      apply    = pending_q && ((state_q == IDLE) || boundary);

      state_d        = state_q;
      presc_d        = presc_q;
      cnt_d          = cnt_q;
      pending_d      = pending_q;
      stg_out_en_d   = stg_out_en_q;
      stg_pwm_en_d   = stg_pwm_en_q;
      stg_duty_d     = stg_duty_q;
      act_out_en_d   = act_out_en_q;
      act_pwm_en_d   = act_pwm_en_q;
      act_duty_d     = act_duty_q;
      period_start_d = boundary;

      // accept needs pending=0 and apply needs pending=1, so they never collide;
      // an accept on a boundary edge therefore waits for the next boundary.
      if (accept) begin
         stg_out_en_d = cfg_out_en;
         stg_pwm_en_d = cfg_pwm_en;
         stg_duty_d   = cfg_duty;
         pending_d    = 1'b1;
      end
      if (apply) begin
         act_out_en_d = stg_out_en_q;
         act_pwm_en_d = stg_pwm_en_q;
         act_duty_d   = stg_duty_q;
         pending_d    = 1'b0;
      end

      case (state_q)
         IDLE: begin
            presc_d = '0;
            cnt_d   = '0;
            if (act_out_en_q != '0) state_d = RUN;
         end
         RUN: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) cnt_d = cnt_q + 1'b1;
            if (boundary && (act_out_en_d == '0)) begin
               state_d = IDLE;
               presc_d = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-channel pin drive, computed from the current counter and active config.
   always_comb begin
      pwm_out_d = '0;
      phase     = cnt_q;
      if (state_q == RUN) begin
         for (int unsigned i = 0; i < 16; i++) begin
`ifdef PWM_STAGGER_EN
            phase = cnt_q + CNT_W'(i * STAGGER);
`else
            phase = cnt_q;
`endif
            if (!act_out_en_q[i])            pwm_out_d[i] = 1'b0;
            else if (!act_pwm_en_q[i])       pwm_out_d[i] = 1'b1;
            else if (act_duty_q == CNT_MAX)  pwm_out_d[i] = 1'b1;
            else                             pwm_out_d[i] = (phase < act_duty_q);
         end
      end
   end

   // All state registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         presc_q        <= '0;
         cnt_q          <= '0;
         pending_q      <= 1'b0;
         stg_out_en_q   <= '0;
         stg_pwm_en_q   <= '0;
         stg_duty_q     <= '0;
         act_out_en_q   <= '0;
         act_pwm_en_q   <= '0;
         act_duty_q     <= '0;
         period_start_q <= 1'b0;
         pwm_out_q      <= '0;
      end else begin
         state_q        <= state_d;
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         pending_q      <= pending_d;
         stg_out_en_q   <= stg_out_en_d;
         stg_pwm_en_q   <= stg_pwm_en_d;
         stg_duty_q     <= stg_duty_d;
         act_out_en_q   <= act_out_en_d;
         act_pwm_en_q   <= act_pwm_en_d;
         act_duty_q     <= act_duty_d;
         period_start_q <= period_start_d;
         pwm_out_q      <= pwm_out_d;
      end
   end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer (default build, CLK_DIV=13, CNT_W=8).
module tb_pwm_sequencer;

   localparam int PERIOD = 256 * 13;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_out_en;
   logic [15:0] cfg_pwm_en;
   logic [7:0]  cfg_duty;
   logic [15:0] pwm_out;
   logic        period_start;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   // results of the last run_period call
   int          r_hi, r_lo, r_ps;
   logic        r_ps_last, r_rdy_a1, r_rdy_b, r_rdy_pre, r_rdy_last, r_busy_last;
   logic [15:0] r_first;

   pwm_sequencer #(.CLK_DIV(13), .CNT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_out_en   (cfg_out_en),
      .cfg_pwm_en   (cfg_pwm_en),
      .cfg_duty     (cfg_duty),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Samples one full period starting right after a period_start sample.
   // Optional offers: at sample a (values *_a) and at sample b (values *_b).
   task automatic run_period(input int a, input logic [15:0] oe_a, input logic [15:0] pe_a,
                             input logic [7:0] du_a, input int b, input logic [15:0] oe_b,
                             input logic [15:0] pe_b, input logic [7:0] du_b);
      r_hi = 0; r_lo = 0; r_ps = 0;
      r_rdy_a1 = 1'bx; r_rdy_b = 1'bx;
      for (int k = 1; k <= PERIOD; k++) begin
         @(negedge clk);
         if (pwm_out == 16'h00FF) r_hi++;
         else if (pwm_out == 16'h0000) r_lo++;
         if (period_start) r_ps++;
         if (k == 1) r_first = pwm_out;
         if (k == a + 1) r_rdy_a1 = cfg_ready;
         if (k == PERIOD - 1) r_rdy_pre = cfg_ready;
         if (k == PERIOD) begin
            r_rdy_last  = cfg_ready;
            r_ps_last   = period_start;
            r_busy_last = busy;
         end
         cfg_valid = 1'b0;
         if (k == a) begin
            cfg_valid = 1'b1; cfg_out_en = oe_a; cfg_pwm_en = pe_a; cfg_duty = du_a;
         end
         if (k == b) begin
            r_rdy_b = cfg_ready;
            cfg_valid = 1'b1; cfg_out_en = oe_b; cfg_pwm_en = pe_b; cfg_duty = du_b;
         end
      end
      cfg_valid = 1'b0;
   endtask

   // Bounded wait for a period_start sample with nothing pending.
   task automatic wait_aligned(output logic timed_out);
      timed_out = 1'b1;
      for (int k = 0; k < 8000; k++) begin
         @(negedge clk);
         if (period_start && cfg_ready) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic offer(input logic [15:0] oe, input logic [15:0] pe, input logic [7:0] du);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_out_en = oe; cfg_pwm_en = pe; cfg_duty = du;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_out_en = '0; cfg_pwm_en = '0; cfg_duty = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, busy, cfg_ready} !== {16'h0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_outputs: got pwm=%h ps=%b busy=%b rdy=%b, want 0000 0 0 1",
                  pwm_out, period_start, busy, cfg_ready);
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({pwm_out, busy, cfg_ready} !== {16'h0, 1'b0, 1'b1})
         $display("FAIL reset_release: got pwm=%h busy=%b rdy=%b, want 0000 0 1",
                  pwm_out, busy, cfg_ready);
      else n_pass++;
   endtask

   task automatic test_static_enable();
      int bad;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_out_en = 16'h0001; cfg_pwm_en = 16'h0000; cfg_duty = 8'h00;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL ready_before_accept: got %b want 1", cfg_ready);
      else n_pass++;
      @(negedge clk);
      cfg_valid = 1'b0;
      n_checks++;
      if (cfg_ready !== 1'b0) $display("FAIL ready_after_accept: got %b want 0", cfg_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({cfg_ready, busy} !== 2'b10)
         $display("FAIL apply_idle: got rdy=%b busy=%b want rdy=1 busy=0", cfg_ready, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL busy_two_cycles: got %b want 1", busy);
      else n_pass++;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (pwm_out !== 16'h0001) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL static_bit0: %0d samples differ from 0001 (last %h)", bad, pwm_out);
      else n_pass++;
   endtask

   task automatic test_pwm_50();
      logic to;
      offer(16'h00FF, 16'h00FF, 8'h80);
      wait_aligned(to);
      n_checks++;
      if (to !== 1'b0) $display("FAIL align_50: got timeout=%b want 0", to);
      else n_pass++;
      run_period(0, '0, '0, '0, 0, '0, '0, '0);
      n_checks++;
      if (r_hi != 1664 || r_lo != 1664 || r_first !== 16'h00FF)
         $display("FAIL duty_50: got hi=%0d lo=%0d first=%h want 1664 1664 00ff", r_hi, r_lo, r_first);
      else n_pass++;
      n_checks++;
      if (r_ps != 1 || r_ps_last !== 1'b1)
         $display("FAIL period_start_50: got count=%0d last=%b want 1 1", r_ps, r_ps_last);
      else n_pass++;
   endtask

   task automatic test_reconfig_mid_period();
      run_period(1000, 16'h00FF, 16'h00FF, 8'h40, 0, '0, '0, '0);
      n_checks++;
      if (r_hi != 1664 || r_lo != 1664)
         $display("FAIL finish_old_period: got hi=%0d lo=%0d want 1664 1664", r_hi, r_lo);
      else n_pass++;
      n_checks++;
      if ({r_rdy_a1, r_rdy_pre, r_rdy_last, r_ps_last} !== 4'b0011)
         $display("FAIL ready_cycle: got a1/pre/last/ps=%b%b%b%b want 0011",
                  r_rdy_a1, r_rdy_pre, r_rdy_last, r_ps_last);
      else n_pass++;
      run_period(0, '0, '0, '0, 0, '0, '0, '0);
      n_checks++;
      if (r_hi != 832 || r_lo != 2496 || r_ps_last !== 1'b1)
         $display("FAIL duty_25: got hi=%0d lo=%0d ps=%b want 832 2496 1", r_hi, r_lo, r_ps_last);
      else n_pass++;
   endtask

   task automatic test_boundaries();
      // stage duty FF, then a second offer while pending must be dropped
      run_period(5, 16'h00FF, 16'h00FF, 8'hFF, 50, 16'hFF00, 16'hFF00, 8'h10);
      n_checks++;
      if (r_rdy_b !== 1'b0 || r_hi != 832 || r_lo != 2496)
         $display("FAIL second_offer: got rdy=%b hi=%0d lo=%0d want 0 832 2496", r_rdy_b, r_hi, r_lo);
      else n_pass++;
      run_period(5, 16'h00FF, 16'h00FF, 8'h00, 0, '0, '0, '0);
      n_checks++;
      if (r_hi != PERIOD || r_ps_last !== 1'b1)
         $display("FAIL duty_max: got hi=%0d ps=%b want %0d 1", r_hi, r_ps_last, PERIOD);
      else n_pass++;
      // offer lands on the boundary edge: staged, applied one period later
      run_period(PERIOD - 1, 16'h00FF, 16'h00FF, 8'h80, 0, '0, '0, '0);
      n_checks++;
      if (r_lo != PERIOD || r_rdy_last !== 1'b0)
         $display("FAIL duty_zero: got lo=%0d rdy=%b want %0d 0", r_lo, r_rdy_last, PERIOD);
      else n_pass++;
      run_period(0, '0, '0, '0, 0, '0, '0, '0);
      n_checks++;
      if (r_lo != PERIOD || r_rdy_pre !== 1'b0 || r_rdy_last !== 1'b1)
         $display("FAIL boundary_accept: got lo=%0d pre=%b last=%b want %0d 0 1",
                  r_lo, r_rdy_pre, r_rdy_last, PERIOD);
      else n_pass++;
   endtask

   task automatic test_disable();
      int bad;
      run_period(10, 16'h0000, 16'h0000, 8'h00, 0, '0, '0, '0);
      n_checks++;
      if (r_hi != 1664 || r_lo != 1664 || r_busy_last !== 1'b0 || r_ps_last !== 1'b1)
         $display("FAIL disable_at_boundary: got hi=%0d lo=%0d busy=%b ps=%b want 1664 1664 0 1",
                  r_hi, r_lo, r_busy_last, r_ps_last);
      else n_pass++;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if ({pwm_out, busy, period_start, cfg_ready} !== {16'h0, 1'b0, 1'b0, 1'b1}) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL idle_after_disable: %0d bad samples, pwm=%h busy=%b", bad, pwm_out, busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_period();
      logic to;
      int   bad;
      offer(16'h00FF, 16'h00FF, 8'h80);
      wait_aligned(to);
      n_checks++;
      if (to !== 1'b0) $display("FAIL align_reset: got timeout=%b want 0", to);
      else n_pass++;
      repeat (500) @(negedge clk);
      offer(16'hFFFF, 16'hFFFF, 8'h20);
      n_checks++;
      if ({pwm_out, cfg_ready} !== {16'h00FF, 1'b0})
         $display("FAIL pre_reset: got pwm=%h rdy=%b want 00ff 0", pwm_out, cfg_ready);
      else n_pass++;
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({pwm_out, busy, period_start, cfg_ready} !== {16'h0, 1'b0, 1'b0, 1'b1})
         $display("FAIL async_reset: got pwm=%h busy=%b ps=%b rdy=%b want 0000 0 0 1",
                  pwm_out, busy, period_start, cfg_ready);
      else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if ({pwm_out, busy, cfg_ready} !== {16'h0, 1'b0, 1'b1}) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL no_stale_config: %0d bad samples, pwm=%h busy=%b", bad, pwm_out, busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_static_enable();
      test_pwm_50();
      test_reconfig_mid_period();
      test_boundaries();
      test_disable();
      test_reset_mid_period();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
